// File: rtl/sys_array_pkg.sv
// ============================================================================
// sys_array_pkg : shared state encoding and width helpers for sys_array_argmax
// Rev 1.0
// ============================================================================
`default_nettype none

package sys_array_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Scores are full-precision products of two DATA_WIDTH operands.
   function automatic int score_w(input int data_width);
      return 2 * data_width;
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/argmax_cmp.sv
// ============================================================================
// argmax_cmp : signed strict-greater selector between running best and candidate
// Rev 1.0
// ============================================================================
`default_nettype none

module argmax_cmp #(
   parameter int SCORE_W = 16,
   parameter int IDX_W   = 4
) (
   input  logic                      load,
   input  logic signed [SCORE_W-1:0] best_val,
   input  logic        [IDX_W-1:0]   best_idx,
   input  logic signed [SCORE_W-1:0] cand_val,
   input  logic        [IDX_W-1:0]   cand_idx,
   output logic signed [SCORE_W-1:0] sel_val,
   output logic        [IDX_W-1:0]   sel_idx
);

   // Strict compare: on a tie the earlier (lower) index is kept.
   always_comb begin
      sel_val = best_val;
      sel_idx = best_idx;
      if (load || (cand_val > best_val)) begin
         sel_val = cand_val;
         sel_idx = cand_idx;
      end
   end

endmodule

`default_nettype wire

// File: rtl/sys_array_argmax.sv
// ============================================================================
// sys_array_argmax : per-row argmax over a snapshot of the systolic score matrix
// Rev 1.0
// ============================================================================
`default_nettype none

module sys_array_argmax
   import sys_array_pkg::*;
#(
   parameter  int DATA_WIDTH = 8,
   parameter  int ARRAY_A_W  = 1,
   parameter  int ARRAY_W_L  = 10,
   localparam int SCORE_W    = score_w(DATA_WIDTH),
   localparam int IDX_W      = idx_w(ARRAY_W_L)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      ready_in,
   input  logic signed [SCORE_W-1:0] scores    [0:ARRAY_A_W-1][0:ARRAY_W_L-1],
   output logic                      busy,
   output logic                      done,
   output logic                      valid,
   output logic        [IDX_W-1:0]   class_idx [0:ARRAY_A_W-1],
   output logic signed [SCORE_W-1:0] max_val   [0:ARRAY_A_W-1]
);

   localparam int ROW_W = idx_w(ARRAY_A_W);

   state_t state, state_nx;

   logic                      ready_q;
   logic                      start;
   logic                      load_snap;
   logic                      last_col;
   logic                      last_row;
   logic        [ROW_W-1:0]   row;
   logic        [IDX_W-1:0]   col;
   logic signed [SCORE_W-1:0] snap [0:ARRAY_A_W-1][0:ARRAY_W_L-1];
   logic signed [SCORE_W-1:0] best_val, sel_val;
   logic        [IDX_W-1:0]   best_idx, sel_idx;

   assign start    = ready_in & ~ready_q;
   assign last_col = (col == IDX_W'(ARRAY_W_L - 1));
   assign last_row = (row == ROW_W'(ARRAY_A_W - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      busy      = 1'b0;
      done      = 1'b0;
      load_snap = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load_snap = 1'b1;
               state_nx  = SCAN;
            end
         end
         SCAN: begin
            busy = 1'b1;
            if (last_col && last_row) state_nx = DONE;
         end
         DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Snapshot decouples the scan from upstream changes; no reset needed.
   always_ff @(posedge clk) begin
      if (load_snap) snap <= scores;
   end

   argmax_cmp #(
      .SCORE_W (SCORE_W),
      .IDX_W   (IDX_W)
   ) u_cmp (
      .load     (col == '0),
      .best_val (best_val),
      .best_idx (best_idx),
      .cand_val (snap[row][col]),
      .cand_idx (col),
      .sel_val  (sel_val),
      .sel_idx  (sel_idx)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ready_q  <= 1'b0;
         valid    <= 1'b0;
         row      <= '0;
         col      <= '0;
         best_val <= '0;
         best_idx <= '0;
         for (int r = 0; r < ARRAY_A_W; r++) begin
            class_idx[r] <= '0;
            max_val[r]   <= '0;
         end
      end else begin
         ready_q <= ready_in;
         if (load_snap) begin
            valid <= 1'b0;
            row   <= '0;
            col   <= '0;
         end else if (state == SCAN) begin
            best_val <= sel_val;
            best_idx <= sel_idx;
            if (last_col) begin
               class_idx[row] <= sel_idx;
               max_val[row]   <= sel_val;
               col            <= '0;
               row            <= last_row ? '0 : row + 1'b1;
               if (last_row) valid <= 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sys_array_argmax.sv
// ============================================================================
// tb_sys_array_argmax : directed self-checking bench for sys_array_argmax
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sys_array_argmax;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // dut1: defaults (1 x 10)
   logic               rdy1 = 1'b0;
   logic signed [15:0] sc1  [0:0][0:9];
   logic               busy1, done1, valid1;
   logic        [3:0]  ci1  [0:0];
   logic signed [15:0] mv1  [0:0];

   // dut2: 2 x 10
   logic               rdy2 = 1'b0;
   logic signed [15:0] sc2  [0:1][0:9];
   logic               busy2, done2, valid2;
   logic        [3:0]  ci2  [0:1];
   logic signed [15:0] mv2  [0:1];

   // dut3: 2 x 1
   logic               rdy3 = 1'b0;
   logic signed [15:0] sc3  [0:1][0:0];
   logic               busy3, done3, valid3;
   logic        [0:0]  ci3  [0:1];
   logic signed [15:0] mv3  [0:1];

   sys_array_argmax dut1 (
      .clk(clk), .reset_n(reset_n), .ready_in(rdy1), .scores(sc1),
      .busy(busy1), .done(done1), .valid(valid1), .class_idx(ci1), .max_val(mv1)
   );

   sys_array_argmax #(.DATA_WIDTH(8), .ARRAY_A_W(2), .ARRAY_W_L(10)) dut2 (
      .clk(clk), .reset_n(reset_n), .ready_in(rdy2), .scores(sc2),
      .busy(busy2), .done(done2), .valid(valid2), .class_idx(ci2), .max_val(mv2)
   );

   sys_array_argmax #(.DATA_WIDTH(8), .ARRAY_A_W(2), .ARRAY_W_L(1)) dut3 (
      .clk(clk), .reset_n(reset_n), .ready_in(rdy3), .scores(sc3),
      .busy(busy3), .done(done3), .valid(valid3), .class_idx(ci3), .max_val(mv3)
   );

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt1 = 0;

   always @(negedge clk) if (done1) done_cnt1 = done_cnt1 + 1;

   int vec_a [10] = '{3, -7, 12, 5, 12, 0, -1, 9, 2, 4};
   int vec_b [10] = '{-5, -3, -9, -3, -100, -8, -7, -6, -4, -2};
   int vec_c [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
   int vec_r0[10] = '{50, -1, 3, 49, 0, 0, 0, 0, 0, 50};
   int vec_r1[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 20};

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load1(input int v [10]);
      for (int i = 0; i < 10; i++) sc1[0][i] = 16'(v[i]);
   endtask

   // Counts cycles until done is seen on the selected instance; -1 on timeout.
   task automatic wait_done(input int which, input int limit, output int lat);
      logic d;
      lat = -1;
      for (int n = 1; n <= limit; n++) begin
         tick();
         case (which)
            1:       d = done1;
            2:       d = done2;
            default: d = done3;
         endcase
         if (d) begin
            lat = n;
            break;
         end
      end
   endtask

   int lat;
   int cnt0;

   initial begin
      load1(vec_a);
      for (int r = 0; r < 2; r++) for (int i = 0; i < 10; i++) sc2[r][i] = '0;
      sc3[0][0] = '0;
      sc3[1][0] = '0;

      // Reset state
      #12;
      check("rst_busy",  busy1,  0);
      check("rst_done",  done1,  0);
      check("rst_valid", valid1, 0);
      check("rst_idx",   ci1[0], 0);
      check("rst_max",   mv1[0], 0);
      check("rst_busy2", busy2,  0);
      tick();
      reset_n = 1'b1;
      tick();
      tick();

      // Mixed scores with a tie on the maximum
      load1(vec_a);
      rdy1 = 1'b1;
      tick();
      check("a_busy_scan",  busy1,  1);
      check("a_valid_scan", valid1, 0);
      wait_done(1, 40, lat);
      check("a_latency", (lat < 0) ? lat : lat + 1, 11);
      check("a_idx",     ci1[0], 2);
      check("a_max",     mv1[0], 12);
      check("a_valid",   valid1, 1);
      tick();
      check("a_done_pulse", done1,  0);
      check("a_busy_idle",  busy1,  0);
      check("a_valid_hold", valid1, 1);
      rdy1 = 1'b0;
      tick();

      // All-negative scores; prior result must hold until row is rewritten
      load1(vec_b);
      rdy1 = 1'b1;
      tick();
      check("b_valid_clr", valid1, 0);
      for (int i = 0; i < 4; i++) tick();
      check("b_max_hold", mv1[0], 12);
      wait_done(1, 40, lat);
      check("b_latency", (lat < 0) ? lat : lat + 5, 11);
      check("b_idx",     ci1[0], 9);
      check("b_max",     mv1[0], -2);
      rdy1 = 1'b0;
      tick();

      // Input changes and ready_in toggling during SCAN are ignored
      load1(vec_c);
      cnt0 = done_cnt1;
      rdy1 = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 10; i++) sc1[0][i] = 16'sd100;
      rdy1 = 1'b0;
      tick();
      rdy1 = 1'b1;
      wait_done(1, 40, lat);
      check("c_latency", (lat < 0) ? lat : lat + 3, 11);
      check("c_idx",     ci1[0], 8);
      check("c_max",     mv1[0], 9);
      for (int i = 0; i < 20; i++) tick();
      check("c_one_done", done_cnt1 - cnt0, 1);
      rdy1 = 1'b0;
      tick();

      // Reset during SCAN cycle 5, ready_in still high at release
      load1(vec_a);
      rdy1 = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      #2;
      reset_n = 1'b0;
      #1;
      check("r_busy",  busy1,  0);
      check("r_done",  done1,  0);
      check("r_valid", valid1, 0);
      check("r_idx",   ci1[0], 0);
      check("r_max",   mv1[0], 0);
      tick();
      tick();
      reset_n = 1'b1;
      wait_done(1, 40, lat);
      check("r_latency", lat, 11);
      check("r_idx2",    ci1[0], 2);
      check("r_max2",    mv1[0], 12);
      rdy1 = 1'b0;
      tick();

      // ready_in held high for 50 cycles gives one scan
      load1(vec_b);
      cnt0 = done_cnt1;
      rdy1 = 1'b1;
      for (int i = 0; i < 50; i++) tick();
      check("h_one_done", done_cnt1 - cnt0, 1);
      check("h_idx",      ci1[0], 9);
      rdy1 = 1'b0;
      tick();

      // Two rows
      for (int i = 0; i < 10; i++) begin
         sc2[0][i] = 16'(vec_r0[i]);
         sc2[1][i] = 16'(vec_r1[i]);
      end
      rdy2 = 1'b1;
      wait_done(2, 60, lat);
      check("m_latency", lat, 21);
      check("m_idx0",    ci2[0], 0);
      check("m_idx1",    ci2[1], 9);
      check("m_max0",    mv2[0], 50);
      check("m_max1",    mv2[1], 20);
      check("m_valid",   valid2, 1);
      rdy2 = 1'b0;

      // Single column per row
      sc3[0][0] = -16'sd4;
      sc3[1][0] = 16'sd7;
      rdy3 = 1'b1;
      wait_done(3, 20, lat);
      check("w1_latency", lat, 3);
      check("w1_idx0",    ci3[0], 0);
      check("w1_max0",    mv3[0], -4);
      check("w1_max1",    mv3[1], 7);
      rdy3 = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sys_array_argmax.md
SYS_ARRAY_ARGMAX -- requirements
Module: sys_array_argmax

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the operand width; scores are signed 2*DATA_WIDTH bits.
REQ-002 SHALL have parameter ARRAY_A_W, default 1, the number of score rows (samples).
REQ-003 SHALL have parameter ARRAY_W_L, default 10, the number of score columns (classes).
REQ-004 SHALL have derived localparam IDX_W = max(1, clog2(ARRAY_W_L)).
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port ready_in  input  1  level "scores valid" from the upstream systolic fetcher.
REQ-008 SHALL have port scores  input  [0:ARRAY_A_W-1][0:ARRAY_W_L-1] x signed 2*DATA_WIDTH  the fetcher output matrix.
REQ-009 SHALL have port busy  output  1  high while a scan is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when results are updated.
REQ-011 SHALL have port valid  output  1  high while class_idx/max_val hold a completed result.
REQ-012 SHALL have port class_idx  output  [0:ARRAY_A_W-1] x IDX_W  per-row argmax column.
REQ-013 SHALL have port max_val  output  [0:ARRAY_A_W-1] x signed 2*DATA_WIDTH  per-row maximum score.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-015 SHALL detect start as ready_in high in the current cycle and low in the previous cycle (registered ready_in).
REQ-016 SHALL, on start in IDLE, capture the whole scores matrix into an internal snapshot, clear valid, and go to SCAN with row=0, col=0.
REQ-017 SHALL ignore start events in SCAN and DONE; the snapshot is not reloaded.
REQ-018 SHALL process exactly one snapshot element per SCAN cycle, row-major, col incrementing first.
REQ-019 SHALL, at col=0, load the running best with element (row,0) and index 0.
REQ-020 SHALL, at col>0, replace the best only if the element is strictly greater (signed compare); ties keep the lower index.
REQ-021 SHALL, at col=ARRAY_W_L-1, write the final best into class_idx[row]/max_val[row], wrap col to 0, and increment row.
REQ-022 SHALL leave SCAN for DONE after the last element of row ARRAY_A_W-1; SCAN lasts exactly ARRAY_A_W*ARRAY_W_L cycles.
REQ-023 SHALL, in DONE, assert done for one cycle, set valid, and return to IDLE on the next edge.
REQ-024 SHALL give latency of start-edge cycle T -> done high in cycle T+ARRAY_A_W*ARRAY_W_L+1 (T+11 with defaults).
REQ-025 SHALL assert busy in SCAN and DONE and deassert it in IDLE.
REQ-026 SHALL hold class_idx and max_val stable outside SCAN; rows not yet rewritten keep prior values during SCAN.
REQ-027 SHALL handle ARRAY_W_L=1 by producing index 0 with the element value, one cycle per row.
REQ-028 SHALL handle ready_in held high continuously as a single start; a new scan requires ready_in to go low, then high.

Reset
REQ-029 SHALL, on reset_n low, asynchronously force state IDLE, busy=0, done=0, valid=0, all class_idx=0, all max_val=0, row/col counters=0, and registered ready_in=0.
REQ-030 SHALL, when reset is asserted mid-SCAN, abandon the scan with no partial results visible; after release, ready_in already high SHALL count as a start.

Structure
REQ-031 SHALL place the FSM state enum and the score-width helper in a shared package, sys_array_pkg.
REQ-032 SHALL instantiate one sub-module, argmax_cmp, a combinational signed strict-greater comparator/selector returning best value and index.

Verification
REQ-033 SHALL test defaults, scores {3,-7,12,5,12,0,-1,9,2,4}, ready_in 0->1 -> done at T+11, class_idx[0]=2 (tie lowest), max_val[0]=12, valid=1.
REQ-034 SHALL test all-negative scores {-5,-3,-9,-3,-100,-8,-7,-6,-4,-2} -> class_idx=9, max_val=-2 (signed compare).
REQ-035 SHALL test ARRAY_A_W=2 with row0 max at col 0 and row1 max at col 9 -> done at T+21, class_idx={0,9}.
REQ-036 SHALL test changing scores and toggling ready_in during SCAN -> results reflect the snapshot, with no restart and done exactly once.
REQ-037 SHALL test reset_n pulsed low at SCAN cycle 5 -> all outputs 0 immediately; with ready_in still high after release -> a fresh scan completes 11 cycles later.
REQ-038 SHALL test ready_in held high for 50 cycles -> exactly one done pulse.
